// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: active-low segment
// patterns (abcdefg) and counter sizing.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ssd_hex_encode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_encode
  import ssd_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_hex)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scanner with double-buffered frames, leading-zero
// blanking and PWM brightness. All pins are registered and active-low.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int TICK_CYCLES = 65536,
  parameter int PWM_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  output logic                  ready,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     enable_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [PWM_BITS-1:0]   bright_in,
  input  logic                  lz_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW     = cnt_width(TICK_CYCLES);
  localparam int SW     = cnt_width(DIGITS);
  localparam int PH_DIV = TICK_CYCLES >> PWM_BITS;
  localparam logic [CW-1:0]       TICK_LAST   = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0]       TICK_PRE    = CW'(TICK_CYCLES - 2);
  localparam logic [SW-1:0]       SLOT_LAST   = SW'(DIGITS - 1);
  localparam logic [PWM_BITS-1:0] BRIGHT_FULL = '1;

  typedef struct packed {
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   en;
    logic [DIGITS-1:0]   dp;
    logic [PWM_BITS-1:0] bright;
    logic                lz;
  } frame_t;

  frame_t            r_shadow, r_active, w_in;
  logic [CW-1:0]     r_tick;
  logic [SW-1:0]     r_slot;
  logic              r_ready, r_frame_tick, r_dp;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;

  logic              w_tick_end, w_frame_end, w_lit, w_blank, w_dp;
  logic [CW-1:0]     w_phase;
  logic [3:0]        w_digit;
  logic [6:0]        w_hex, w_seg;
  logic [DIGITS-1:0] w_an, w_lz_blank;
  logic [DIGITS:1]   w_hi_nz;

  assign w_in        = {digits_in, enable_in, dp_in, bright_in, lz_in};
  assign w_tick_end  = (r_tick == TICK_LAST);
  assign w_frame_end = w_tick_end && (r_slot == SLOT_LAST);

  // w_hi_nz[i]: some digit at position i or above is non-zero
  assign w_hi_nz[DIGITS] = 1'b0;
  assign w_lz_blank[0]   = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_lz
    assign w_hi_nz[i]    = w_hi_nz[i+1] | (|r_active.digits[4*i +: 4]);
    assign w_lz_blank[i] = r_active.lz & ~w_hi_nz[i];
  end

  assign w_digit = r_active.digits[{r_slot, 2'b00} +: 4];
  assign w_phase = r_tick / CW'(PH_DIV);
  assign w_lit   = (r_active.bright == BRIGHT_FULL) || (w_phase < CW'(r_active.bright));
  assign w_blank = !r_active.en[r_slot] || w_lz_blank[r_slot];

  ssd_hex_encode u_hex (
    .i_hex (w_digit),
    .o_seg (w_hex)
  );

  // Anode stays off on tick 0 so segment changes settle before the digit lights
  always_comb begin
    w_an  = '1;
    w_seg = SEG_BLANK;
    w_dp  = 1'b1;
    if (w_lit) begin
      if (r_tick != '0) w_an = ~(DIGITS'(1) << r_slot);
      if (!w_blank) begin
        w_seg = w_hex;
        w_dp  = ~r_active.dp[r_slot];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick       <= '0;
      r_slot       <= '0;
      r_ready      <= 1'b1;
      r_shadow     <= '0;
      r_active     <= '0;
      r_frame_tick <= 1'b0;
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
    end else begin
      r_tick <= w_tick_end ? '0 : r_tick + 1'b1;
      if (w_tick_end) r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
      // ready low means a shadow frame is pending, so the two branches are exclusive
      if (load && r_ready) begin
        r_shadow <= w_in;
        r_ready  <= 1'b0;
      end else if (w_frame_end && !r_ready) begin
        r_active <= r_shadow;
        r_ready  <= 1'b1;
      end
      // Looks one cycle ahead so the registered pulse lands on the terminal cycle
      r_frame_tick <= (r_tick == TICK_PRE) && (r_slot == SLOT_LAST);
      r_an         <= w_an;
      r_seg        <= w_seg;
      r_dp         <= w_dp;
    end
  end

  assign ready      = r_ready;
  assign frame_tick = r_frame_tick;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: expected pins per cycle are queued up
// front, a negedge monitor pops and compares them.
module tb_ssd_scan_ctrl;

  localparam int D  = 4;
  localparam int TC = 16;
  localparam int B  = 3;        // reset released after edge 3
  localparam int B2 = B + 400;  // mid-run reset edge

  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, lz_in = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  enable_in = '0, dp_in = '0;
  logic [1:0]  bright_in = '0;
  logic        ready, dp, frame_tick;
  logic [6:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.DIGITS(D), .TICK_CYCLES(TC), .PWM_BITS(2)) dut (
    .clk(clk), .rst(rst), .load(load), .ready(ready),
    .digits_in(digits_in), .enable_in(enable_in), .dp_in(dp_in),
    .bright_in(bright_in), .lz_in(lz_in),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  en;
    logic [3:0]  dpm;
    logic [1:0]  br;
    logic        lz;
  } frm_t;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       rdy;
    logic       ft;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  frm_t F_DARK = '{16'h0000, 4'h0, 4'h0, 2'd0, 1'b0};
  frm_t L1     = '{16'h12AF, 4'hF, 4'h0, 2'd3, 1'b0};
  frm_t L2     = '{16'h0030, 4'hF, 4'b0101, 2'd3, 1'b1};
  frm_t L3     = '{16'h12AF, 4'hF, 4'h0, 2'd1, 1'b0};
  frm_t LIGN   = '{16'hFFFF, 4'hF, 4'hF, 2'd3, 1'b0};
  frm_t L4     = '{16'h12AF, 4'hF, 4'h0, 2'd0, 1'b0};
  frm_t L5     = '{16'h5678, 4'b1011, 4'b0010, 2'd3, 1'b0};
  frm_t L6     = '{16'h1111, 4'hF, 4'h0, 2'd3, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  // Ready is low from each accepted load until the swapping frame boundary
  function automatic logic exp_rdy(input int r);
    int lo [6] = '{1, 66, 130, 194, 320, 389};
    int hi [6] = '{63, 127, 191, 255, 383, 399};
    exp_rdy = 1'b1;
    for (int i = 0; i < 6; i++)
      if (r >= lo[i] && r <= hi[i]) exp_rdy = 1'b0;
  endfunction

  task automatic push_rst(input int c);
    exp_t e;
    e.cyc = c; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.rdy = 1'b1; e.ft = 1'b0;
    q.push_back(e);
  endtask

  // Pins after edge base+n reflect slot/tick state n-1 of the frame shown
  task automatic push_range(input int base, input int nf, input int nt, input frm_t f);
    for (int n = nf; n <= nt; n++) begin
      exp_t e;
      int   s, tk, sl;
      logic lit, blank;
      s  = n - 1;
      tk = s % TC;
      sl = (s / TC) % D;
      e.cyc = base + n; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      lit   = (f.br == 2'd3) || ((tk / 4) < int'(f.br));
      blank = !f.en[sl] || (f.lz && sl > 0 && (f.dig >> (4 * sl)) == 16'h0);
      if (lit) begin
        if (tk != 0) e.an = ~(4'b0001 << sl);
        if (!blank) begin
          e.seg = HEX[f.dig[4*sl +: 4]];
          e.dp  = ~f.dpm[sl];
        end
      end
      e.ft  = ((n % 64) == 63);
      e.rdy = exp_rdy(base + n - B);
      q.push_back(e);
    end
  endtask

  task automatic at_edge(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int c, input frm_t f);
    at_edge(c - 1);
    digits_in = f.dig; enable_in = f.en; dp_in = f.dpm; bright_in = f.br; lz_in = f.lz;
    load = 1'b1;
    at_edge(c);
    load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      m_e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL stale_expect cyc=%0d expected entry for cyc %0d never compared", cyc, m_e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      m_e = q.pop_front();
      n_cmp++;
      if ({an, seg, dp, ready, frame_tick} !== {m_e.an, m_e.seg, m_e.dp, m_e.rdy, m_e.ft}) begin
        n_bad++;
        $display("FAIL pins cyc=%0d got an=%b seg=%b dp=%b rdy=%b ft=%b want an=%b seg=%b dp=%b rdy=%b ft=%b",
                 cyc, an, seg, dp, ready, frame_tick, m_e.an, m_e.seg, m_e.dp, m_e.rdy, m_e.ft);
      end
    end
    if (cyc >= 1) begin
      n_cmp++;
      if ($countones(~an) > 1) begin
        n_bad++;
        $display("FAIL an_onehot cyc=%0d got an=%b want at most one low bit", cyc, an);
      end
    end
  end

  initial begin
    for (int c = 1; c <= B; c++) push_rst(c);
    push_range(B, 1, 64, F_DARK);
    push_range(B, 65, 128, L1);
    push_range(B, 129, 192, L2);
    push_range(B, 193, 256, L3);
    push_range(B, 257, 320, L4);
    push_range(B, 321, 384, L4);   // L5 landed on frame_tick, not swapped yet
    push_range(B, 385, 399, L5);
    push_rst(B2);
    push_range(B2, 1, 192, F_DARK);

    at_edge(B);
    rst = 1'b0;
    do_load(B + 1, L1);
    do_load(B + 66, L2);
    do_load(B + 130, L3);
    do_load(B + 140, LIGN);        // ready low: must be ignored
    do_load(B + 194, L4);
    do_load(B + 320, L5);          // accepted on the frame_tick cycle
    do_load(B + 389, L6);          // pending when reset hits
    at_edge(B2 - 1);
    rst = 1'b1;
    at_edge(B2);
    rst = 1'b0;
    at_edge(B2 + 194);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d entries left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
